i2c_reg_cfg: RTL and testbench
==============================

// Module: i2c_reg_cfg
// PURPOSE
//  Register-init sequencer that sits directly upstream of the I2C master. After power-up it
//  walks a {16-bit reg addr, 8-bit data} table held in an external synchronous ROM and issues
//  one I2C write per entry through the master's wr_en/i2c_start/byte_addr/wr_data interface.
//  It waits for i2c_end after each entry and raises cfg_done when the table is exhausted.
//  Clocked by the master's i2c_clk output (1 MHz at default master settings), fed into sys_clk.
// PARAMETERS
//  REG_NUM   8'd200     number of table entries; valid indices 0..REG_NUM-1
//  PWR_DLY   15'd20000  sys_clk cycles waited after reset before entry 0 (20 ms at 1 MHz)
//  GAP_CYC   4'd8       idle sys_clk cycles inserted between successive I2C transactions
//  DLY_UNIT  10'd1000   sys_clk cycles per unit of a delay-marker entry
// PORTS
//  sys_clk     in   1   clock (i2c_clk of the I2C master)
//  sys_rst_n   in   1   asynchronous reset, active low
//  cfg_start   in   1   1-cycle pulse; restarts the table from entry 0 (accepted only in DONE)
//  cfg_idx     out  8   ROM address
//  cfg_data    in   24  ROM word {addr[23:8], data[7:0]}, valid 1 cycle after cfg_idx changes
//  i2c_end     in   1   1-cycle pulse from the master: transaction finished
//  rd_data     in   8   master read data, valid when i2c_end pulses after a read
//  i2c_start   out  1   1-cycle start pulse to the master
//  wr_en       out  1   write select, held for the whole transaction
//  rd_en       out  1   read select, held for the whole transaction (0 unless readback is built in)
//  addr_num    out  1   tied 1: 16-bit register addresses
//  byte_addr   out  16  register address, held stable from the i2c_start pulse to i2c_end
//  wr_data     out  8   register data, held stable from the i2c_start pulse to i2c_end
//  cfg_busy    out  1   high in every state except DONE
//  cfg_done    out  1   high in DONE; sticky until cfg_start
// BEHAVIOUR
//  - Reset values: state=PWR_WAIT; cfg_idx=0; i2c_start, wr_en, rd_en, cfg_done=0; cfg_busy=1;
//    byte_addr=0; wr_data=0. Reset asserted mid-transaction aborts immediately: no further
//    i2c_start is issued and nothing is committed.
//  - FSM:
//    - PWR_WAIT: count to PWR_DLY-1, then go to FETCH.
//    - FETCH: 1 wait cycle for ROM latency; then latch cfg_data into byte_addr/wr_data.
//      - If addr==16'hFFFF (delay marker): go to DLY.
//      - Otherwise: go to ISSUE.
//    - ISSUE: i2c_start=1 and wr_en=1 for exactly 1 cycle; then go to WAIT_END.
//      wr_en stays 1 until i2c_end.
//    - WAIT_END: wait for i2c_end, with no timeout. On i2c_end: drop wr_en, go to GAP.
//      An i2c_end seen in any other state is ignored.
//    - DLY: wait data*DLY_UNIT cycles; data==0 means 0 wait cycles. No I2C traffic. Then go to GAP.
//    - GAP: wait GAP_CYC cycles. Then:
//      - If cfg_idx==REG_NUM-1: go to DONE.
//      - Otherwise: cfg_idx+1, go to FETCH.
//    - DONE: cfg_done=1, cfg_busy=0. cfg_start restarts at cfg_idx=0 via FETCH, skipping PWR_WAIT.
//  - Start-to-start spacing: at least 1 ISSUE cycle + transaction + GAP_CYC + 2 FETCH cycles.
//    At most one transaction is outstanding at any time.
//  - cfg_start outside DONE is ignored. cfg_start in the same cycle as the DONE entry is ignored.
//  - cfg_idx never exceeds REG_NUM-1, so there is no wrap-around. REG_NUM=1 is legal.
// CONFIGURATION
//  I2C_READBACK_EN defined:
//  - After each write's GAP, issue a read of the same byte_addr: rd_en=1, wr_en=0, 1-cycle
//    i2c_start, then wait for i2c_end.
//  - Compare rd_data with wr_data. On mismatch, set sticky cfg_err (out, 1) and increment
//    err_cnt (out, 8, saturating at 255).
//  - Then run a second GAP and advance. Delay markers are never read back.
//  - Both cfg_err and err_cnt reset to 0, and clear on an accepted cfg_start.
//  I2C_READBACK_EN undefined: no read phase, rd_en is constant 0, and the cfg_err/err_cnt
//  ports do not exist.
// TESTING
//  1. Reset, ROM of 3 entries {3008,02},{3103,03},{3017,FF}, master model acks:
//     -> no i2c_start for 20000 cycles; then 3 starts with byte_addr 3008/3103/3017;
//     -> cfg_done rises GAP_CYC cycles after the 3rd i2c_end.
//  2. Entry {FFFF,05} between two writes -> no i2c_start for 5000 cycles + GAP.
//     cfg_idx advances; the next write is issued normally.
//  3. Master delays i2c_end by 300 cycles -> byte_addr/wr_data/wr_en are stable throughout.
//     Exactly one i2c_start per entry.
//  4. In DONE pulse cfg_start -> cfg_done=0 next cycle; table replays from idx 0 with no 20000-cycle wait.
//     cfg_start mid-table -> ignored.
//  5. Assert sys_rst_n=0 during WAIT_END of entry 1 -> all outputs return to reset values.
//     After release, PWR_WAIT reruns and the table restarts at idx 0.
//  6. (I2C_READBACK_EN) Model returns 8'h00 for reg 3103 (wrote 03) -> cfg_err=1, err_cnt=1.
//     Other entries: no error; cfg_done still asserts.

Source files
------------

// File: rtl/i2c_reg_cfg_if.sv
// Sequencer-side bus: ROM fetch port plus the I2C master command port.
// master = sequencer, slave = ROM and I2C master.
interface i2c_reg_cfg_if;
  logic [7:0]  cfg_idx;
  logic [23:0] cfg_data;
  logic        i2c_end;
  logic [7:0]  rd_data;
  logic        i2c_start;
  logic        wr_en;
  logic        rd_en;
  logic        addr_num;
  logic [15:0] byte_addr;
  logic [7:0]  wr_data;

  modport master (
    output cfg_idx, i2c_start, wr_en, rd_en,
    output addr_num, byte_addr, wr_data,
    input  cfg_data, i2c_end, rd_data
  );

  modport slave (
    input  cfg_idx, i2c_start, wr_en, rd_en,
    input  addr_num, byte_addr, wr_data,
    output cfg_data, i2c_end, rd_data
  );
endinterface

// File: rtl/i2c_reg_cfg.sv
// Register-init sequencer: walks a {addr16,data8} ROM, one I2C write per entry.
// Define I2C_READBACK_EN to add a verify read per write (cfg_err/err_cnt).
module i2c_reg_cfg #(
  parameter logic [7:0]  REG_NUM  = 8'd200,
  parameter logic [14:0] PWR_DLY  = 15'd20000,
  parameter logic [3:0]  GAP_CYC  = 4'd8,
  parameter logic [9:0]  DLY_UNIT = 10'd1000
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       cfg_start,
  output logic       cfg_busy,
  output logic       cfg_done,
`ifdef I2C_READBACK_EN
  output logic       cfg_err,
  output logic [7:0] err_cnt,
`endif
  i2c_reg_cfg_if.master bus
);
  typedef enum logic [3:0] {
    PWR_WAIT, FETCH, ISSUE, WAIT_END, DLY,
    GAP, RD_ISSUE, RD_WAIT, DONE
  } state_t;

  state_t      state, state_nx;
  logic [17:0] cnt, cnt_nx;
  logic [7:0]  idx, idx_nx;
  logic [15:0] addr, addr_nx;
  logic [7:0]  data, data_nx;
  logic        rb_pend, rb_nx;
  logic [17:0] pwr_last, gap_last, dly_last;
  logic        marker;

`ifdef I2C_READBACK_EN
  localparam logic RB = 1'b1;
  logic       err_nx;
  logic [7:0] ecnt_nx;
`else
  localparam logic RB = 1'b0;
`endif

  assign pwr_last = 18'(PWR_DLY) - 18'd1;
  assign gap_last = 18'(GAP_CYC) - 18'd1;
  assign dly_last = 18'(data) * 18'(DLY_UNIT) - 18'd1;
  assign marker   = (bus.cfg_data[23:8] == 16'hFFFF);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt + 18'd1;
    idx_nx   = idx;
    addr_nx  = addr;
    data_nx  = data;
    rb_nx    = rb_pend;
`ifdef I2C_READBACK_EN
    err_nx   = cfg_err;
    ecnt_nx  = err_cnt;
`endif
    unique case (state)
      PWR_WAIT: if (cnt == pwr_last) begin
        state_nx = FETCH;
        cnt_nx   = '0;
      end
      // second FETCH cycle: ROM word for idx is now valid
      FETCH: if (cnt[0]) begin
        cnt_nx  = '0;
        addr_nx = bus.cfg_data[23:8];
        data_nx = bus.cfg_data[7:0];
        rb_nx   = 1'b0;
        if (!marker)
          state_nx = ISSUE;
        else if (bus.cfg_data[7:0] == 8'd0)
          state_nx = GAP;
        else
          state_nx = DLY;
      end
      ISSUE: begin
        state_nx = WAIT_END;
        cnt_nx   = '0;
      end
      WAIT_END: begin
        cnt_nx = '0;
        if (bus.i2c_end) begin
          state_nx = GAP;
          rb_nx    = RB;
        end
      end
      DLY: if (cnt == dly_last) begin
        state_nx = GAP;
        cnt_nx   = '0;
      end
      GAP: if (cnt == gap_last) begin
        cnt_nx = '0;
        if (rb_pend)
          state_nx = RD_ISSUE;
        else if (idx == REG_NUM - 8'd1)
          state_nx = DONE;
        else begin
          idx_nx   = idx + 8'd1;
          state_nx = FETCH;
        end
      end
      RD_ISSUE: begin
        state_nx = RD_WAIT;
        cnt_nx   = '0;
      end
      RD_WAIT: begin
        cnt_nx = '0;
        if (bus.i2c_end) begin
          state_nx = GAP;
          rb_nx    = 1'b0;
`ifdef I2C_READBACK_EN
          if (bus.rd_data != data) begin
            err_nx = 1'b1;
            if (err_cnt != 8'hFF)
              ecnt_nx = err_cnt + 8'd1;
          end
`endif
        end
      end
      DONE: begin
        cnt_nx = '0;
        if (cfg_start) begin
          state_nx = FETCH;
          idx_nx   = '0;
`ifdef I2C_READBACK_EN
          err_nx   = 1'b0;
          ecnt_nx  = '0;
`endif
        end
      end
      default: begin
        state_nx = PWR_WAIT;
        cnt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state   <= PWR_WAIT;
      cnt     <= '0;
      idx     <= '0;
      addr    <= '0;
      data    <= '0;
      rb_pend <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      idx     <= idx_nx;
      addr    <= addr_nx;
      data    <= data_nx;
      rb_pend <= rb_nx;
    end
  end

`ifdef I2C_READBACK_EN
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cfg_err <= 1'b0;
      err_cnt <= '0;
    end else begin
      cfg_err <= err_nx;
      err_cnt <= ecnt_nx;
    end
  end

  assign bus.rd_en = (state == RD_ISSUE) ||
                     (state == RD_WAIT);
`else
  assign bus.rd_en = 1'b0;
`endif

  assign bus.cfg_idx   = idx;
  assign bus.byte_addr = addr;
  assign bus.wr_data   = data;
  assign bus.addr_num  = 1'b1;
  assign bus.i2c_start = (state == ISSUE) ||
                         (state == RD_ISSUE);
  assign bus.wr_en     = (state == ISSUE) ||
                         (state == WAIT_END);
  assign cfg_done      = (state == DONE);
  assign cfg_busy      = !cfg_done;
endmodule

// File: tb/tb_i2c_reg_cfg.sv
// Bench for i2c_reg_cfg: ROM and I2C master models, table-walk timing model.
// Build with +define+I2C_READBACK_EN to cover the verify-read variant.
module tb_i2c_reg_cfg;
  localparam int N    = 6;
  localparam int PWR  = 20000;
  localparam int GAP  = 8;
  localparam int UNIT = 1000;
`ifdef I2C_READBACK_EN
  localparam int RB = 1;
`else
  localparam int RB = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cfg_start = 1'b0;
  logic cfg_busy, cfg_done;
`ifdef I2C_READBACK_EN
  logic       cfg_err;
  logic [7:0] err_cnt;
`endif

  i2c_reg_cfg_if bus();

  i2c_reg_cfg #(
    .REG_NUM (8'(N)),
    .PWR_DLY (15'(PWR)),
    .GAP_CYC (4'(GAP)),
    .DLY_UNIT(10'(UNIT))
  ) dut (
    .sys_clk  (clk),
    .sys_rst_n(rst_n),
    .cfg_start(cfg_start),
    .cfg_busy (cfg_busy),
    .cfg_done (cfg_done),
`ifdef I2C_READBACK_EN
    .cfg_err  (cfg_err),
    .err_cnt  (err_cnt),
`endif
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  // synchronous ROM, one cycle of address-to-data latency
  logic [23:0] rom [256];
  initial begin
    logic [7:0] idx_q;
    idx_q = '0;
    bus.cfg_data = '0;
    forever begin
      @(negedge clk);
      bus.cfg_data = rom[idx_q];
      idx_q = bus.cfg_idx;
    end
  end

  // I2C master model: records every transaction, checks hold/overlap
  int          st_edge[$];
  int          end_edge[$];
  logic [15:0] st_addr[$];
  logic [7:0]  st_data[$];
  logic        st_rd[$];
  int          viol = 0;
  bit          bad = 1'b0;
  bit          stray = 1'b0;
  logic [7:0]  mem [logic [15:0]];

  initial begin
    bit          busy;
    int          left;
    logic [15:0] ha;
    logic [7:0]  hd;
    logic        hw, hr;
    busy = 1'b0; left = 0;
    ha = '0; hd = '0; hw = 1'b0; hr = 1'b0;
    bus.i2c_end = 1'b0;
    bus.rd_data = '0;
    forever begin
      @(negedge clk);
      bus.i2c_end = 1'b0;
      if (!rst_n) begin
        busy = 1'b0;
      end else if (busy) begin
        if (bus.i2c_start || bus.byte_addr !== ha ||
            bus.wr_data !== hd || bus.wr_en !== hw ||
            bus.rd_en !== hr)
          viol++;
        left--;
        if (left == 0) begin
          busy = 1'b0;
          bus.i2c_end = 1'b1;
          end_edge.push_back(cyc + 1);
          if (hr)
            bus.rd_data = (bad && ha == 16'h3103) ?
                          8'h00 : mem[ha];
        end
      end else if (bus.i2c_start) begin
        busy = 1'b1;
        ha = bus.byte_addr; hd = bus.wr_data;
        hw = bus.wr_en;     hr = bus.rd_en;
        st_edge.push_back(cyc);
        st_addr.push_back(ha);
        st_data.push_back(hd);
        st_rd.push_back(hr);
        if (hw) mem[ha] = hd;
        if (hw == hr) viol++;
        left = (ha == 16'h3103) ? 300 :
               int'($urandom_range(1, 20));
      end else if (stray) begin
        stray = 1'b0;
        bus.i2c_end = 1'b1;
      end
    end
  end

  task automatic clear_log();
    st_edge.delete(); end_edge.delete();
    st_addr.delete(); st_data.delete();
    st_rd.delete();
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_start"}, bus.i2c_start, 0);
    chk({tag, "_wr_en"}, bus.wr_en, 0);
    chk({tag, "_rd_en"}, bus.rd_en, 0);
    chk({tag, "_done"}, cfg_done, 0);
    chk({tag, "_busy"}, cfg_busy, 1);
    chk({tag, "_addr"}, bus.byte_addr, 0);
    chk({tag, "_data"}, bus.wr_data, 0);
    chk({tag, "_idx"}, bus.cfg_idx, 0);
    chk({tag, "_anum"}, bus.addr_num, 1);
`ifdef I2C_READBACK_EN
    chk({tag, "_err"}, cfg_err, 0);
    chk({tag, "_ecnt"}, err_cnt, 0);
`endif
  endtask

  task automatic wait_done(input int limit, output int e);
    e = -1;
    for (int n = 0; n < limit; n++) begin
      @(negedge clk);
      if (cfg_done) begin
        e = cyc;
        break;
      end
    end
  endtask

  task automatic wait_3103(input int limit);
    for (int n = 0; n < limit; n++) begin
      @(negedge clk);
      if (st_addr.size() > 0 &&
          st_addr[st_addr.size()-1] == 16'h3103 &&
          !st_rd[st_rd.size()-1])
        return;
    end
    chk("wait_3103_timeout", st_addr.size(), 99);
  endtask

  // base = edge at which the FETCH of entry 0 begins
  task automatic check_run(input string tag,
                           input int base, input int de);
    int t, k;
    logic [15:0] a;
    logic [7:0] d;
    t = base; k = 0;
    for (int i = 0; i < N; i++) begin
      a = rom[i][23:8];
      d = rom[i][7:0];
      if (a == 16'hFFFF) begin
        t += 2 + int'(d) * UNIT + GAP;
      end else begin
        t += 2;
        for (int p = 0; p <= RB; p++) begin
          if (k >= st_edge.size() || k >= end_edge.size()) begin
            chk({tag, "_missing"}, st_edge.size(), k + 1);
            return;
          end
          chk({tag, "_edge"}, st_edge[k], t);
          chk({tag, "_addr"}, st_addr[k], a);
          if (p == 0) chk({tag, "_data"}, st_data[k], d);
          chk({tag, "_rd"}, st_rd[k], p);
          t = end_edge[k] + GAP;
          k++;
        end
      end
    end
    chk({tag, "_count"}, st_edge.size(), k);
    chk({tag, "_done_edge"}, de, t);
  endtask

  initial begin
    int base, de, nst;
    for (int i = 0; i < 256; i++) rom[i] = '0;
    rom[0] = 24'h300802;
    rom[1] = 24'h310303;
    rom[2] = 24'hFFFF05;
    rom[3] = {16'h3017, 8'($urandom)};
    rom[4] = 24'hFFFF00;
    rom[5] = {16'h3000 + 16'($urandom_range(32, 255)),
              8'($urandom)};

    repeat (3) @(negedge clk);
    check_reset("rst0");

    bad = (RB != 0);
    rst_n = 1'b1;
    base = cyc + PWR;
    wait_done(30000, de);
    check_run("run1", base, de);
`ifdef I2C_READBACK_EN
    chk("run1_err", cfg_err, 1);
    chk("run1_ecnt", err_cnt, 1);
`endif
    chk("run1_viol", viol, 0);

    nst = st_edge.size();
    stray = 1'b1;
    repeat (4) @(negedge clk);
    chk("stray_done", cfg_done, 1);
    chk("stray_starts", st_edge.size(), nst);

    clear_log();
    bad = 1'b0;
    cfg_start = 1'b1;
    base = cyc + 1;
    @(negedge clk);
    cfg_start = 1'b0;
    chk("restart_done", cfg_done, 0);
    chk("restart_busy", cfg_busy, 1);
    wait_3103(2000);
    repeat (50) @(negedge clk);
    cfg_start = 1'b1;
    chk("mid_busy", cfg_busy, 1);
    @(negedge clk);
    cfg_start = 1'b0;
    wait_done(30000, de);
    check_run("run2", base, de);
`ifdef I2C_READBACK_EN
    chk("run2_err", cfg_err, 0);
    chk("run2_ecnt", err_cnt, 0);
`endif
    chk("run2_viol", viol, 0);

    clear_log();
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    wait_3103(2000);
    repeat (50) @(negedge clk);
    chk("pre_rst_wr_en", bus.wr_en, 1);
    rst_n = 1'b0;
    #1;
    check_reset("rst1");
    repeat (5) @(negedge clk);
    clear_log();
    rst_n = 1'b1;
    base = cyc + PWR;
    wait_done(30000, de);
    check_run("run3", base, de);
    chk("run3_viol", viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
